// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Music-box note sequencer. Fetches packed note words from a
//               synchronous song ROM and drives a one-hot note bus plus octave
//               for the tone generator. Each note is timed in duration units
//               and followed by a fixed silent gap. Supports song select with
//               wrap, pause/resume, end-of-song marker, looping and a
//               song_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int UNIT_DIV = 8,
   parameter int GAP_DIV  = 1000,
   parameter int ADDR_W   = 16,
   parameter int SONG_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [11:0]       rom_data,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [ADDR_W-1:0] song_base,
   input  logic [SONG_W-1:0] last_song,
   input  logic              loop_en,
   input  logic              pause_p,
   input  logic              next_p,
   input  logic              prev_p,
   output logic [SONG_W-1:0] sel,
   output logic [15:0]       note_onehot,
   output logic [2:0]        octave,
   output logic              playing,
   output logic              song_done
);

   // Cycle counts for one duration unit and for the silent inter-note gap.
   localparam logic [31:0] UNIT = 32'(CLK_HZ / UNIT_DIV);
   localparam logic [31:0] GAP  = 32'(CLK_HZ / GAP_DIV);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FETCH = 3'd2,
      S_CAPT  = 3'd3,
      S_NOTE  = 3'd4,
      S_GAP   = 3'd5,
      S_END   = 3'd6
   } state_t;

   state_t            state_q,       state_d;
   logic              playing_q,     playing_d;
   logic [SONG_W-1:0] sel_q,         sel_d;
   logic [ADDR_W-1:0] rom_addr_q,    rom_addr_d;
   logic [3:0]        note_q,        note_d;
   logic [2:0]        octave_q,      octave_d;
   logic [31:0]       cnt_q,         cnt_d;
   logic              song_done_q,   song_done_d;
   logic [15:0]       note_onehot_q, note_onehot_d;

   // Fields of the ROM word {note, octave, duration}.
   logic [3:0] rom_note;
   logic [2:0] rom_oct;
   logic [4:0] rom_dur;

   assign rom_note = rom_data[11:8];
   assign rom_oct  = rom_data[7:5];
   assign rom_dur  = rom_data[4:0];

   // Next-state logic: song select has top priority, then pause, then the
   // sequencing FSM. A paused sequencer freezes everything except LOAD/END.
   always_comb begin
      state_d       = state_q;
      playing_d     = playing_q;
      sel_d         = sel_q;
      rom_addr_d    = rom_addr_q;
      note_d        = note_q;
      octave_d      = octave_q;
      cnt_d         = cnt_q;
      song_done_d   = 1'b0;
      note_onehot_d = 16'd0;

      if (next_p || prev_p) begin
         // Select aborts the current note; LOAD picks up the new song_base
         // once the lookup table has settled on the new sel.
         if (next_p) begin
            sel_d = (sel_q >= last_song) ? '0 : sel_q + 1'b1;
         end else begin
            sel_d = (sel_q == '0) ? last_song : sel_q - 1'b1;
         end
         cnt_d   = 32'd0;
         state_d = S_LOAD;
      end else begin
         if (pause_p) begin
            playing_d = ~playing_q;
         end

         case (state_q)
            S_IDLE: begin
               if (playing_d) begin
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               rom_addr_d = song_base;
               state_d    = playing_d ? S_FETCH : S_IDLE;
            end
            S_FETCH: begin
               if (playing_q) begin
                  state_d = S_CAPT;
               end
            end
            S_CAPT: begin
               if (playing_q) begin
                  if (rom_dur == 5'd0) begin
                     state_d = S_END;
                  end else begin
                     note_d   = rom_note;
                     octave_d = rom_oct;
                     cnt_d    = ({27'd0, rom_dur} * UNIT) - 32'd1;
                     state_d  = S_NOTE;
                  end
               end
            end
            S_NOTE: begin
               if (playing_q) begin
                  if (cnt_q == 32'd0) begin
                     cnt_d   = GAP - 32'd1;
                     state_d = S_GAP;
                  end else begin
                     cnt_d = cnt_q - 32'd1;
                  end
               end
            end
            S_GAP: begin
               if (playing_q) begin
                  if (cnt_q == 32'd0) begin
                     rom_addr_d = rom_addr_q + 1'b1;
                     state_d    = S_FETCH;
                  end else begin
                     cnt_d = cnt_q - 32'd1;
                  end
               end
            end
            S_END: begin
               if (!loop_en) begin
                  playing_d = 1'b0;
               end
               state_d = S_LOAD;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Outputs are registered, so decode them from the upcoming state.
      song_done_d = (state_d == S_END);
      if ((state_d == S_NOTE) && playing_d && (note_d != 4'd0)) begin
         note_onehot_d = 16'd1 << note_d;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         playing_q     <= 1'b0;
         sel_q         <= '0;
         rom_addr_q    <= '0;
         note_q        <= 4'd0;
         octave_q      <= 3'd0;
         cnt_q         <= 32'd0;
         song_done_q   <= 1'b0;
         note_onehot_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         playing_q     <= playing_d;
         sel_q         <= sel_d;
         rom_addr_q    <= rom_addr_d;
         note_q        <= note_d;
         octave_q      <= octave_d;
         cnt_q         <= cnt_d;
         song_done_q   <= song_done_d;
         note_onehot_q <= note_onehot_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign sel         = sel_q;
   assign note_onehot = note_onehot_q;
   assign octave      = octave_q;
   assign playing     = playing_q;
   assign song_done   = song_done_q;

endmodule
`default_nettype wire
